pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage ARM pipeline. Drives the freeze/flush

---
 rtl/pipeline_hazard_ctrl_if.sv | 74 +++++++
 rtl/pipeline_hazard_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Groups every signal between the 5-stage pipeline and its central
//   stall/flush controller.
//
//   Pipeline -> controller (driven through the master modport):
//     ID_Rn, ID_Rm, ID_use_Rn, ID_two_src      operands of the ID instruction
//     EXE_WB_EN, EXE_MEM_R_EN, EXE_Dest        writer / load in EXE
//     MEM_WB_EN, MEM_Dest                      writer in MEM
//     B_taken                                  branch resolved taken in EXE
//     mem_req, mem_ready                       SRAM access handshake
//     err_clr                                  clears mem_timeout_err
//
//   Controller -> pipeline (driven through the slave modport):
//     pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze   hold a register
//     if_id_flush, id_ex_flush, mem_wb_flush                 load a bubble
//     mem_timeout_err                                        sticky timeout flag
//     stall_cnt                                              saturating stall count
//     fsm_state, wait_cnt                                    SRAM-wait FSM debug view
//
//   SRAM handshake: mem_req is held high by the MEM stage for the whole
//   access; the access completes in the cycle where mem_req and mem_ready
//   are both high. A cycle with mem_req=1 and mem_ready=0 is a wait cycle.
//   Dropping mem_req before mem_ready abandons the access.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       ID_Rn;
    logic [3:0]       ID_Rm;
    logic             ID_use_Rn;
    logic             ID_two_src;
    logic             EXE_WB_EN;
    logic             EXE_MEM_R_EN;
    logic [3:0]       EXE_Dest;
    logic             MEM_WB_EN;
    logic [3:0]       MEM_Dest;
    logic             B_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             err_clr;

    logic             pc_freeze;
    logic             if_id_freeze;
    logic             id_ex_freeze;
    logic             ex_mem_freeze;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic             fsm_state;
    logic [7:0]       wait_cnt;

    modport master (
        output ID_Rn, ID_Rm, ID_use_Rn, ID_two_src,
        output EXE_WB_EN, EXE_MEM_R_EN, EXE_Dest,
        output MEM_WB_EN, MEM_Dest,
        output B_taken, mem_req, mem_ready, err_clr,
        input  pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
        input  if_id_flush, id_ex_flush, mem_wb_flush,
        input  mem_timeout_err, stall_cnt, fsm_state, wait_cnt
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_use_Rn, ID_two_src,
        input  EXE_WB_EN, EXE_MEM_R_EN, EXE_Dest,
        input  MEM_WB_EN, MEM_Dest,
        input  B_taken, mem_req, mem_ready, err_clr,
        output pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
        output if_id_flush, id_ex_flush, mem_wb_flush,
        output mem_timeout_err, stall_cnt, fsm_state, wait_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage ARM pipeline. It decides,
//   every cycle, which stage registers hold and which load a bubble, from:
//     - RAW hazards between the ID instruction and the EXE/MEM writers,
//     - a branch resolved taken in EXE,
//     - SRAM accesses that take more than one cycle.
//   SRAM waits are tracked by a two-state FSM that raises a sticky error
//   after MEM_TIMEOUT wait cycles. A saturating counter records how many
//   cycles the PC was frozen.
//
// Parameters
//   FWD_EN       1: forwarding exists, stall only on load-use
//                0: stall on any RAW against EXE or MEM
//   MEM_TIMEOUT  wait cycles (8-bit) after which mem_timeout_err is set
//   CNT_W        width of stall_cnt (must match the interface CNT_W)
//
// Ports
//   clk   pipeline clock, rising edge
//   rst   asynchronous, active-low reset; also forces all freeze/flush low
//   hz    pipeline_hazard_ctrl_if.slave, all pipeline-facing signals
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter bit          FWD_EN      = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Hazard detection (pure combinational)
    // ------------------------------------------------------------------
    logic hz_exe;
    logic hz_mem;
    logic stall_d;
    logic mwait;

    always_comb begin
        hz_exe = hz.EXE_WB_EN &
                 ((hz.ID_use_Rn  & (hz.ID_Rn == hz.EXE_Dest)) |
                  (hz.ID_two_src & (hz.ID_Rm == hz.EXE_Dest)));
        hz_mem = hz.MEM_WB_EN &
                 ((hz.ID_use_Rn  & (hz.ID_Rn == hz.MEM_Dest)) |
                  (hz.ID_two_src & (hz.ID_Rm == hz.MEM_Dest)));
        // With forwarding only a load in EXE cannot supply its result in time.
        if (FWD_EN) begin
            stall_d = hz_exe & hz.EXE_MEM_R_EN;
        end else begin
            stall_d = hz_exe | hz_mem;
        end
        mwait = hz.mem_req & ~hz.mem_ready;
    end

    // ------------------------------------------------------------------
    // SRAM wait FSM: state register
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic [7:0] wait_cnt_inc;
    logic       timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // SRAM wait FSM: next-state logic
    //   wait_cnt counts completed wait cycles of the current access. On a
    //   timeout the FSM falls back to IDLE; if SRAM is still not ready the
    //   next cycle re-enters WAIT with wait_cnt=1, so the error is re-armed
    //   every MEM_TIMEOUT cycles while the stall continues.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_hit  = 1'b0;
        wait_cnt_inc = wait_cnt + 8'd1;
        case (state)
            ST_IDLE: begin
                if (mwait) begin
                    if (8'd1 >= TIMEOUT_LIM) begin
                        timeout_hit  = 1'b1;
                        state_nxt    = ST_IDLE;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (hz.mem_ready || !hz.mem_req) begin
                    // Completed, or abandoned by the MEM stage: no error.
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt_inc >= TIMEOUT_LIM) begin
                    timeout_hit  = 1'b1;
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt_inc;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    //   Freeze/flush follow the live mwait rather than the FSM state, so
    //   the pipeline releases in the very cycle SRAM answers and stays
    //   frozen across a timeout. A taken branch during an SRAM wait is not
    //   lost: EXE is frozen, so B_taken is still presented after release.
    //   All controls are forced low while rst is asserted.
    // ------------------------------------------------------------------
    logic pc_frz;
    logic if_id_frz;
    logic id_ex_frz;
    logic ex_mem_frz;
    logic if_id_fl;
    logic id_ex_fl;
    logic mem_wb_fl;

    always_comb begin
        pc_frz     = 1'b0;
        if_id_frz  = 1'b0;
        id_ex_frz  = 1'b0;
        ex_mem_frz = 1'b0;
        if_id_fl   = 1'b0;
        id_ex_fl   = 1'b0;
        mem_wb_fl  = 1'b0;
        if (rst) begin
            if (mwait) begin
                pc_frz     = 1'b1;
                if_id_frz  = 1'b1;
                id_ex_frz  = 1'b1;
                ex_mem_frz = 1'b1;
                mem_wb_fl  = 1'b1;
            end else if (hz.B_taken) begin
                // The stalled ID instruction is on the wrong path: squash it.
                if_id_fl = 1'b1;
                id_ex_fl = 1'b1;
            end else if (stall_d) begin
                pc_frz    = 1'b1;
                if_id_frz = 1'b1;
                id_ex_fl  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag and saturating stall counter
    // ------------------------------------------------------------------
    logic             err_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            // A new timeout wins over a simultaneous clear.
            err_q <= 1'b1;
        end else if (hz.err_clr) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (pc_frz && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign hz.pc_freeze       = pc_frz;
    assign hz.if_id_freeze    = if_id_frz;
    assign hz.id_ex_freeze    = id_ex_frz;
    assign hz.ex_mem_freeze   = ex_mem_frz;
    assign hz.if_id_flush     = if_id_fl;
    assign hz.id_ex_flush     = id_ex_fl;
    assign hz.mem_wb_flush    = mem_wb_fl;
    assign hz.mem_timeout_err = err_q;
    assign hz.stall_cnt       = stall_q;
    assign hz.fsm_state       = state;
    assign hz.wait_cnt        = wait_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two controllers side by side, one with forwarding (FWD_EN=1) and one
//   without (FWD_EN=0), both with MEM_TIMEOUT=8. Both see identical
//   stimulus; directed vectors with hand-computed expectations.
//   Control vector order: {pc, if_id_frz, id_ex_frz, ex_mem_frz,
//                          if_id_flush, id_ex_flush, mem_wb_flush}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] NONE  = 7'b0000_000;
    localparam logic [6:0] MEMW  = 7'b1111_001;
    localparam logic [6:0] STALL = 7'b1100_010;
    localparam logic [6:0] BR    = 7'b0000_110;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) if_f ();
    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) if_n ();

    pipeline_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) u_fwd (
        .clk (clk),
        .rst (rst),
        .hz  (if_f.slave)
    );

    pipeline_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) u_nofwd (
        .clk (clk),
        .rst (rst),
        .hz  (if_n.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sampling ----------------
    function automatic logic [6:0] outs_f();
        return {if_f.pc_freeze, if_f.if_id_freeze, if_f.id_ex_freeze, if_f.ex_mem_freeze,
                if_f.if_id_flush, if_f.id_ex_flush, if_f.mem_wb_flush};
    endfunction

    function automatic logic [6:0] outs_n();
        return {if_n.pc_freeze, if_n.if_id_freeze, if_n.id_ex_freeze, if_n.ex_mem_freeze,
                if_n.if_id_flush, if_n.id_ex_flush, if_n.mem_wb_flush};
    endfunction

    // ---------------- drivers (same stimulus to both DUTs) ----------------
    task automatic drive_id(input logic [3:0] rn, input logic use_rn,
                            input logic [3:0] rm, input logic two_src);
        if_f.ID_Rn = rn; if_f.ID_use_Rn = use_rn; if_f.ID_Rm = rm; if_f.ID_two_src = two_src;
        if_n.ID_Rn = rn; if_n.ID_use_Rn = use_rn; if_n.ID_Rm = rm; if_n.ID_two_src = two_src;
    endtask

    task automatic drive_exe(input logic wb, input logic mr, input logic [3:0] dest);
        if_f.EXE_WB_EN = wb; if_f.EXE_MEM_R_EN = mr; if_f.EXE_Dest = dest;
        if_n.EXE_WB_EN = wb; if_n.EXE_MEM_R_EN = mr; if_n.EXE_Dest = dest;
    endtask

    task automatic drive_mem(input logic wb, input logic [3:0] dest);
        if_f.MEM_WB_EN = wb; if_f.MEM_Dest = dest;
        if_n.MEM_WB_EN = wb; if_n.MEM_Dest = dest;
    endtask

    task automatic drive_ctl(input logic b, input logic req, input logic rdy, input logic clr);
        if_f.B_taken = b; if_f.mem_req = req; if_f.mem_ready = rdy; if_f.err_clr = clr;
        if_n.B_taken = b; if_n.mem_req = req; if_n.mem_ready = rdy; if_n.err_clr = clr;
    endtask

    task automatic idle_inputs();
        drive_id(4'd0, 1'b0, 4'd0, 1'b0);
        drive_exe(1'b0, 1'b0, 4'd0);
        drive_mem(1'b0, 4'd0);
        drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        drive_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        drive_id(4'd3, 1'b1, 4'd3, 1'b1);
        drive_exe(1'b1, 1'b1, 4'd3);
        #2;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL rst_outs_fwd: got %b expected %b", outs_f(), NONE); end
        checks++; if (outs_n() !== NONE) begin errors++; $display("FAIL rst_outs_nofwd: got %b expected %b", outs_n(), NONE); end
        tick();
        checks++; if (if_f.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", if_f.stall_cnt); end
        checks++; if (if_f.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", if_f.mem_timeout_err); end
        checks++; if (if_f.fsm_state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b expected 0", if_f.fsm_state); end
        checks++; if (if_f.wait_cnt !== 8'd0) begin errors++; $display("FAIL rst_wait_cnt: got %0d expected 0", if_f.wait_cnt); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        // EXE: LDR R3 ; ID: ADD R1, R3, R2
        drive_id(4'd3, 1'b1, 4'd2, 1'b1);
        drive_exe(1'b1, 1'b1, 4'd3);
        drive_mem(1'b0, 4'd0);
        #1;
        checks++; if (outs_f() !== STALL) begin errors++; $display("FAIL lu_stall_fwd: got %b expected %b", outs_f(), STALL); end
        checks++; if (outs_n() !== STALL) begin errors++; $display("FAIL lu_stall_nofwd: got %b expected %b", outs_n(), STALL); end
        tick();
        // Bubble now in EXE, load moved to MEM: forwarding resolves it.
        drive_exe(1'b0, 1'b0, 4'd0);
        drive_mem(1'b1, 4'd3);
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL lu_release_fwd: got %b expected %b", outs_f(), NONE); end
        checks++; if (outs_n() !== STALL) begin errors++; $display("FAIL lu_mem_raw_nofwd: got %b expected %b", outs_n(), STALL); end
        // Same RAW but EXE is an ALU op, not a load.
        drive_mem(1'b0, 4'd0);
        drive_exe(1'b1, 1'b0, 4'd3);
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL alu_raw_fwd: got %b expected %b", outs_f(), NONE); end
        checks++; if (outs_n() !== STALL) begin errors++; $display("FAIL alu_raw_nofwd: got %b expected %b", outs_n(), STALL); end
        // Load to R3 but ID does not read Rn.
        drive_id(4'd3, 1'b0, 4'd2, 1'b1);
        drive_exe(1'b1, 1'b1, 4'd3);
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL lu_rn_unused: got %b expected %b", outs_f(), NONE); end
        idle_inputs();
        tick();
    endtask

    task automatic test_raw_nofwd();
        drive_exe(1'b0, 1'b0, 4'd0);
        drive_mem(1'b1, 4'd5);
        drive_id(4'd0, 1'b1, 4'd5, 1'b1);
        #1;
        checks++; if (outs_n() !== STALL) begin errors++; $display("FAIL mem_rm_nofwd: got %b expected %b", outs_n(), STALL); end
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL mem_rm_fwd: got %b expected %b", outs_f(), NONE); end
        drive_id(4'd0, 1'b1, 4'd5, 1'b0);
        #1;
        checks++; if (outs_n() !== NONE) begin errors++; $display("FAIL mem_rm_no_two_src: got %b expected %b", outs_n(), NONE); end
        drive_mem(1'b0, 4'd5);
        drive_id(4'd0, 1'b1, 4'd5, 1'b1);
        #1;
        checks++; if (outs_n() !== NONE) begin errors++; $display("FAIL mem_wb_off: got %b expected %b", outs_n(), NONE); end
        drive_mem(1'b1, 4'd15);
        drive_id(4'd15, 1'b1, 4'd0, 1'b0);
        #1;
        checks++; if (outs_n() !== STALL) begin errors++; $display("FAIL mem_r15: got %b expected %b", outs_n(), STALL); end
        drive_mem(1'b1, 4'd14);
        #1;
        checks++; if (outs_n() !== NONE) begin errors++; $display("FAIL mem_dest_diff: got %b expected %b", outs_n(), NONE); end
        idle_inputs();
        tick();
    endtask

    task automatic test_branch_priority();
        drive_id(4'd3, 1'b1, 4'd2, 1'b1);
        drive_exe(1'b1, 1'b1, 4'd3);
        drive_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (outs_f() !== BR) begin errors++; $display("FAIL br_over_stall_fwd: got %b expected %b", outs_f(), BR); end
        checks++; if (outs_n() !== BR) begin errors++; $display("FAIL br_over_stall_nofwd: got %b expected %b", outs_n(), BR); end
        drive_ctl(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (outs_f() !== MEMW) begin errors++; $display("FAIL memw_over_br: got %b expected %b", outs_f(), MEMW); end
        drive_ctl(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (outs_f() !== BR) begin errors++; $display("FAIL br_after_ready: got %b expected %b", outs_f(), BR); end
        idle_inputs();
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (outs_f() !== MEMW) begin errors++; $display("FAIL memw_cycle%0d: got %b expected %b", i, outs_f(), MEMW); end
            tick();
        end
        drive_ctl(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL memw_release: got %b expected %b", outs_f(), NONE); end
        checks++; if (if_f.stall_cnt !== 16'd4) begin errors++; $display("FAIL memw_stall_cnt: got %0d expected 4", if_f.stall_cnt); end
        checks++; if (if_f.wait_cnt !== 8'd4) begin errors++; $display("FAIL memw_wait_cnt: got %0d expected 4", if_f.wait_cnt); end
        checks++; if (if_f.fsm_state !== 1'b1) begin errors++; $display("FAIL memw_state_wait: got %b expected 1", if_f.fsm_state); end
        tick();
        drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (if_f.fsm_state !== 1'b0) begin errors++; $display("FAIL memw_state_idle: got %b expected 0", if_f.fsm_state); end
        checks++; if (if_f.wait_cnt !== 8'd0) begin errors++; $display("FAIL memw_wait_clr: got %0d expected 0", if_f.wait_cnt); end
        checks++; if (if_f.stall_cnt !== 16'd4) begin errors++; $display("FAIL memw_stall_hold: got %0d expected 4", if_f.stall_cnt); end
        checks++; if (if_f.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL memw_no_err: got %b expected 0", if_f.mem_timeout_err); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if (outs_n() !== MEMW) begin errors++; $display("FAIL to_frz_cycle%0d: got %b expected %b", i, outs_n(), MEMW); end
            tick();
            if (i == 7) begin
                checks++; if (if_f.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_err: got %b expected 0", if_f.mem_timeout_err); end
            end
        end
        checks++; if (if_f.mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_fwd: got %b expected 1", if_f.mem_timeout_err); end
        checks++; if (if_n.mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_nofwd: got %b expected 1", if_n.mem_timeout_err); end
        checks++; if (if_f.fsm_state !== 1'b0) begin errors++; $display("FAIL to_state_idle: got %b expected 0", if_f.fsm_state); end
        checks++; if (if_f.stall_cnt !== 16'd8) begin errors++; $display("FAIL to_stall_cnt: got %0d expected 8", if_f.stall_cnt); end
        checks++; if (outs_f() !== MEMW) begin errors++; $display("FAIL to_still_frozen: got %b expected %b", outs_f(), MEMW); end
        tick();
        checks++; if (if_f.wait_cnt !== 8'd1) begin errors++; $display("FAIL to_restart_cnt: got %0d expected 1", if_f.wait_cnt); end
        drive_ctl(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if (if_f.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_err_clr: got %b expected 0", if_f.mem_timeout_err); end
        // err_clr held high through the next timeout: the set must win.
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 5) begin
                checks++; if (if_f.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL to_clr_hold: got %b expected 0", if_f.mem_timeout_err); end
            end
        end
        checks++; if (if_f.mem_timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_over_clr: got %b expected 1", if_f.mem_timeout_err); end
        drive_ctl(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_ctl(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_ctl(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checks++; if (if_f.wait_cnt !== 8'd2) begin errors++; $display("FAIL ar_pre_wait_cnt: got %0d expected 2", if_f.wait_cnt); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL ar_outs_fwd: got %b expected %b", outs_f(), NONE); end
        checks++; if (outs_n() !== NONE) begin errors++; $display("FAIL ar_outs_nofwd: got %b expected %b", outs_n(), NONE); end
        checks++; if (if_f.stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_stall_cnt: got %0d expected 0", if_f.stall_cnt); end
        checks++; if (if_f.fsm_state !== 1'b0) begin errors++; $display("FAIL ar_state: got %b expected 0", if_f.fsm_state); end
        checks++; if (if_f.wait_cnt !== 8'd0) begin errors++; $display("FAIL ar_wait_cnt: got %0d expected 0", if_f.wait_cnt); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Load-use held for three cycles, then a branch, then a one-cycle SRAM access.
        drive_id(4'd7, 1'b0, 4'd7, 1'b1);
        drive_exe(1'b1, 1'b1, 4'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (outs_f() !== STALL) begin errors++; $display("FAIL b2b_stall%0d: got %b expected %b", i, outs_f(), STALL); end
            tick();
        end
        checks++; if (if_f.stall_cnt !== 16'd3) begin errors++; $display("FAIL b2b_stall_cnt: got %0d expected 3", if_f.stall_cnt); end
        drive_ctl(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive_ctl(1'b0, 1'b1, 1'b1, 1'b0);
        drive_exe(1'b0, 1'b0, 4'd0);
        #1;
        checks++; if (outs_f() !== NONE) begin errors++; $display("FAIL b2b_single_cycle_mem: got %b expected %b", outs_f(), NONE); end
        tick();
        checks++; if (if_f.fsm_state !== 1'b0) begin errors++; $display("FAIL b2b_state: got %b expected 0", if_f.fsm_state); end
        checks++; if (if_f.stall_cnt !== 16'd3) begin errors++; $display("FAIL b2b_stall_final: got %0d expected 3", if_f.stall_cnt); end
        idle_inputs();
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        test_reset();
        test_load_use();
        test_raw_nofwd();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
